// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU retire-trace buffer: FSM states, record layout, record width.
// Build option: define CPU_TRACE_TIMESTAMP_EN to add a 32-bit capture timestamp to every record.
// Record layout, MSB to LSB: [ts], pc, instr, wb_en, wb_reg, wb_data.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int TS_W = 32;

`ifdef CPU_TRACE_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif

  // Record view at the default widths (ADDR_W=32, DATA_W=32, REG_AW=5).
  typedef struct packed {
`ifdef CPU_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
    logic [31:0]     pc;
    logic [31:0]     instr;
    logic            wb_en;
    logic [4:0]      wb_reg;
    logic [31:0]     wb_data;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  // Record width for arbitrary field widths; matches the layout of trace_rec_t.
  function automatic int rec_width(input int addr_w, input int data_w, input int reg_aw);
    return addr_w + data_w + 1 + reg_aw + data_w + TS_EN * TS_W;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace record storage: DEPTH x W simple dual-port memory.
// Latency: write lands on the clock edge; read is combinational from the address.
// Backpressure: none; the owner guarantees it never writes an entry it still needs.
module trace_ram
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = REC_W
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Synchronous write port; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Retire-trace capture: triggered, stop-when-full or wrapping circular record buffer, show-ahead drain port.
// Latency: a retire is stored on the next edge; records are readable the first cycle in DONE.
// Backpressure: the drain port only advances on rd_valid && rd_ready; capture never stalls the CPU.
// Build option: CPU_TRACE_TIMESTAMP_EN adds a free-running cycle counter and the rd_ts port.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              retire,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              arm,
  input  logic              stop,
  input  logic              trig_any,
  input  logic [ADDR_W-1:0] trig_pc,
  input  logic              wrap_mode,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_instr,
  output logic              rd_wb_en,
  output logic [REG_AW-1:0] rd_wb_reg,
  output logic [DATA_W-1:0] rd_wb_data
`ifdef CPU_TRACE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]   rd_ts
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int RW     = rec_width(ADDR_W, DATA_W, REG_AW);
  localparam int O_REG  = DATA_W;
  localparam int O_EN   = O_REG + REG_AW;
  localparam int O_INS  = O_EN + 1;
  localparam int O_PC   = O_INS + DATA_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               wr_en;
  logic               hit;
  logic               full;
  logic               has_rec;
  logic               rd_fire;
  logic [RW-1:0]      wr_rec;
  logic [RW-1:0]      rd_rec;

  assign hit      = retire && (trig_any || (pc == trig_pc));
  assign full     = (count_q == FULL);
  assign has_rec  = (count_q != '0);
  assign rd_valid = (state_q == ST_DONE) && has_rec;
  assign rd_fire  = rd_valid && rd_ready;

`ifdef CPU_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end

  assign wr_rec = {ts_q, pc, instr, wb_en, wb_reg, wb_data};
  assign rd_ts  = has_rec ? rd_rec[O_PC + ADDR_W +: TS_W] : '0;
`else
  assign wr_rec = {pc, instr, wb_en, wb_reg, wb_data};
`endif

  // Next-state: arm overrides everything; a retire paired with stop is recorded before stopping.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    if (arm) begin
      state_d  = ST_ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (hit) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + ONE;
            state_d  = stop ? ST_DONE : ST_CAPTURE;
          end else if (stop) begin
            state_d = ST_DONE;
          end
        end
        ST_CAPTURE: begin
          if (retire) begin
            if (full && !wrap_mode) begin
              // Full after wrap was switched off: nowhere to put it, so capture ends here.
              state_d = ST_DONE;
            end else begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              if (full) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                ovf_d    = 1'b1;
              end else begin
                count_d = count_q + ONE;
                if (!wrap_mode && (count_q == FULL - ONE)) state_d = ST_DONE;
              end
            end
          end
          if (stop) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_rec),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_rec)
  );

  assign state_o    = state_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign rd_pc      = has_rec ? rd_rec[O_PC  +: ADDR_W] : '0;
  assign rd_instr   = has_rec ? rd_rec[O_INS +: DATA_W] : '0;
  assign rd_wb_en   = has_rec ? rd_rec[O_EN]            : 1'b0;
  assign rd_wb_reg  = has_rec ? rd_rec[O_REG +: REG_AW] : '0;
  assign rd_wb_data = has_rec ? rd_rec[0     +: DATA_W] : '0;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer at DEPTH=4.
// Inputs change 1ns after the rising edge; outputs are checked in the same window.
// Also covers the timestamp port when CPU_TRACE_TIMESTAMP_EN is defined.
module tb_cpu_trace_buffer;

  localparam int CW = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire, wb_en, arm, stop, trig_any, wrap_mode, rd_ready;
  logic [31:0] pc, instr, wb_data, trig_pc;
  logic [4:0]  wb_reg;
  logic [1:0]  state_o;
  logic [CW-1:0] count;
  logic        overflow, rd_valid, rd_wb_en;
  logic [31:0] rd_pc, rd_instr, rd_wb_data;
  logic [4:0]  rd_wb_reg;
`ifdef CPU_TRACE_TIMESTAMP_EN
  logic [31:0] rd_ts;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .retire(retire), .pc(pc), .instr(instr),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .arm(arm), .stop(stop), .trig_any(trig_any), .trig_pc(trig_pc),
    .wrap_mode(wrap_mode), .state_o(state_o), .count(count),
    .overflow(overflow), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_wb_en(rd_wb_en),
    .rd_wb_reg(rd_wb_reg), .rd_wb_data(rd_wb_data)
`ifdef CPU_TRACE_TIMESTAMP_EN
    , .rd_ts(rd_ts)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one retiring instruction; other fields are derived from pc.
  task automatic put(input logic [31:0] p);
    retire  = 1'b1;
    pc      = p;
    instr   = 32'hA500_0000 | p;
    wb_en   = p[2];
    wb_reg  = p[6:2];
    wb_data = ~p;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

`ifdef CPU_TRACE_TIMESTAMP_EN
  logic [31:0] ts0;
`endif

  initial begin
    rst = 1'b1; retire = 0; pc = 0; instr = 0; wb_en = 0; wb_reg = 0; wb_data = 0;
    arm = 0; stop = 0; trig_any = 0; trig_pc = 0; wrap_mode = 0; rd_ready = 0;
    #1;
    check("rst_state", state_o, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_rdpc", rd_pc, 0);
    step(); step();
    rst = 1'b0;

    // IDLE ignores retire and stop.
    put(32'h100); stop = 1'b1;
    step();
    retire = 0; stop = 0;
    check("idle_state", state_o, 0);
    check("idle_count", count, 0);

    // Trigger on pc 0x8.
    trig_any = 0; trig_pc = 32'h8; wrap_mode = 0;
    do_arm();
    check("armed_state", state_o, 1);
    put(32'h0); step();
    put(32'h4); step();
    check("pretrig_state", state_o, 1);
    check("pretrig_count", count, 0);
    put(32'h8); step();
    check("trig_state", state_o, 2);
    check("trig_count", count, 1);
    put(32'hC); step();
    retire = 0; stop = 1; step(); stop = 0;
    check("tp_state", state_o, 3);
    check("tp_count", count, 2);
    check("tp_valid", rd_valid, 1);
    check("tp_pc0", rd_pc, 32'h8);
    check("tp_ins0", rd_instr, 32'hA500_0008);
    step();
    check("hold_pc", rd_pc, 32'h8);
    check("hold_count", count, 2);
    rd_ready = 1; step();
    check("tp_pc1", rd_pc, 32'hC);
    check("tp_wbd1", rd_wb_data, 32'hFFFF_FFF3);
    check("tp_wbr1", rd_wb_reg, 5'd3);
    check("tp_wbe1", rd_wb_en, 1);
    step();
    check("tp_empty_valid", rd_valid, 0);
    check("tp_empty_count", count, 0);
    check("tp_empty_pc", rd_pc, 0);
    rd_ready = 0;

    // Stop-when-full with trigger on any retire.
    trig_any = 1; wrap_mode = 0;
    do_arm();
    for (int i = 0; i < 6; i++) begin
      put(32'(i * 4)); step();
      if (i == 3) check("full_done", state_o, 3);
    end
    retire = 0;
    check("full_count", count, 4);
    check("full_ovf", overflow, 0);
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_rd%0d", i), rd_pc, 32'(i * 4));
      step();
    end
    check("full_drained", count, 0);
    rd_ready = 0;

    // Wrap mode: six retires into four slots.
    wrap_mode = 1;
    do_arm();
    for (int i = 0; i < 6; i++) begin
      put(32'(i * 4)); step();
    end
    retire = 0;
    check("wrap_state_cap", state_o, 2);
    stop = 1; step(); stop = 0;
    check("wrap_state", state_o, 3);
    check("wrap_count", count, 4);
    check("wrap_ovf", overflow, 1);
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_rd%0d", i), rd_pc, 32'(8 + i * 4));
      step();
    end
    rd_ready = 0;
    wrap_mode = 0;

    // Retire together with stop in CAPTURE keeps the record.
    do_arm();
    check("arm_clr_ovf", overflow, 0);
    put(32'h40); step();
    put(32'h44); stop = 1; step();
    retire = 0; stop = 0;
    check("rs_state", state_o, 3);
    check("rs_count", count, 2);
    check("rs_pc", rd_pc, 32'h40);

    // arm and stop together in DONE: arm wins.
    arm = 1; stop = 1; step(); arm = 0; stop = 0;
    check("as_state", state_o, 1);
    check("as_count", count, 0);

    // Triggering retire together with stop in ARMED.
    put(32'h80); stop = 1; step();
    retire = 0; stop = 0;
    check("ats_state", state_o, 3);
    check("ats_count", count, 1);
    check("ats_pc", rd_pc, 32'h80);

    // Asynchronous reset mid-capture.
    do_arm();
    put(32'h10); step();
    put(32'h14); step();
    retire = 0;
    check("pre_rst_count", count, 2);
    #2 rst = 1;
    #1;
    check("mrst_state", state_o, 0);
    check("mrst_count", count, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_valid", rd_valid, 0);
    step();
    rst = 0;

`ifdef CPU_TRACE_TIMESTAMP_EN
    // Two records captured 3 cycles apart carry timestamps 3 apart.
    for (int i = 0; i < 9; i++) step();
    do_arm();
    put(32'h200); step();
    retire = 0; step(); step();
    put(32'h204); step();
    retire = 0; stop = 1; step(); stop = 0;
    ts0 = rd_ts;
    rd_ready = 1; step(); rd_ready = 0;
    check("ts_delta", rd_ts - ts0, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Parametrised, synthesizable successor to the MultiCycle_CPU observation harness.
- Captures one record per retired instruction into an on-chip circular buffer: PC, instruction word, writeback register, writeback data.
- Capture can start on a trigger PC and runs in stop-when-full or wrap mode.
- Sits beside MultiCycle_CPU, fed from its PC, IR and register-file write signals; a debug/bench master drains it over a valid/ready port.

Parameters:
- ADDR_W, 32, PC width.
- DATA_W, 32, instruction and writeback data width.
- REG_AW, 5, register index width.
- DEPTH, 16, number of records; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the fill count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- retire  in  1  one-cycle pulse: instruction completes (PCWre of the final state).
- pc  in  ADDR_W  PC of the retiring instruction.
- instr  in  DATA_W  IR contents of the retiring instruction.
- wb_en  in  1  RegWre asserted for this instruction.
- wb_reg  in  REG_AW  destination register.
- wb_data  in  DATA_W  writeback value.
- arm  in  1  pulse: clear the buffer and enter ARMED.
- stop  in  1  pulse: end capture.
- trig_any  in  1  1 = trigger on the first retire; 0 = trigger on pc == trig_pc.
- trig_pc  in  ADDR_W  trigger address.
- wrap_mode  in  1  0 = stop when full; 1 = overwrite oldest.
- state_o  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- count  out  CNT_W  records held.
- overflow  out  1  at least one record was overwritten in wrap mode.
- rd_valid  out  1  a record is available.
- rd_ready  in  1  consumer accepts the record.
- rd_pc, rd_instr, rd_wb_en, rd_wb_reg, rd_wb_data  out  record fields  oldest record (show-ahead).

Behaviour:
- Reset (async, active-high): state IDLE; wr_ptr, rd_ptr, count and overflow are 0; rd_valid is 0. RAM contents are don't-care. All rd_* outputs read 0 while count = 0.
- arm (any state): on the next edge, state goes to ARMED; pointers, count and overflow are cleared. arm has priority over stop and retire in the same cycle.
- IDLE: retire and stop are ignored.
- ARMED:
  - retire with (trig_any or pc == trig_pc) writes that record as entry 0 and moves to CAPTURE.
  - stop moves to DONE with count 0.
  - A triggering retire together with stop records the entry, then goes to DONE.
- CAPTURE:
  - Each retire writes {pc, instr, wb_en, wb_reg, wb_data} at wr_ptr; wr_ptr increments modulo DEPTH.
  - wrap_mode = 0: the write that makes count = DEPTH moves to DONE. No retire is dropped before that point.
  - wrap_mode = 1: at count = DEPTH, a write also advances rd_ptr, keeps count = DEPTH and sets overflow (sticky until arm/rst).
  - stop moves to DONE. A retire in the same cycle is recorded first.
- wrap_mode is sampled every cycle. Changing it mid-capture is legal and takes effect on the next write.
- DONE: retire is ignored. rd_valid = (count != 0).
  - A handshake (rd_valid and rd_ready) advances rd_ptr modulo DEPTH and decrements count on the edge.
  - rd_* show the oldest entry combinationally from rd_ptr.
- rd_valid is 0 in IDLE, ARMED and CAPTURE regardless of count.
- Latency: a record written on edge N is reflected in count after edge N, and is readable the first cycle in DONE.
- Trigger compare is full-width equality. wb_data is stored even when wb_en = 0.

Optional Feature:
- Macro: CPU_TRACE_TIMESTAMP_EN.
- With the macro defined:
  - A 32-bit free-running cycle counter runs; rst sets it to 0, it increments every clk and wraps at 2^32.
  - Its value at the capture edge is stored per record.
  - It is exposed on an extra output port rd_ts (32 bits), which follows the same show-ahead rules.
- Without the macro: no counter, no rd_ts port, and the record width excludes the timestamp.

Decomposition:
- Package cpu_trace_pkg holds:
  - the state encoding constants ST_IDLE / ST_ARMED / ST_CAPTURE / ST_DONE;
  - the record struct/typedef (conditional ts field);
  - a record-width constant.
- One sub-module, trace_ram: DEPTH x record-width simple dual-port memory, synchronous write, asynchronous read.
- FSM, pointers and count stay in cpu_trace_buffer.

Test Plan:
- All tests use DEPTH=4.
- Reset mid-CAPTURE with count=2 asserts rst → same cycle: state_o=0, count=0, overflow=0, rd_valid=0.
- arm, trig_any=0, trig_pc=0x0000_0008; retire pc 0x0, 0x4, 0x8, 0xC; then stop → DONE, count=2. Reads return pc 0x8 then 0xC; rd_valid then drops.
- wrap_mode=0, trig_any=1, six retires with pc 0x00..0x14 → DONE after the 4th. count=4, overflow=0, reads 0x00, 0x04, 0x08, 0x0C.
- wrap_mode=1, six retires, then stop → count=4, overflow=1, reads 0x08, 0x0C, 0x10, 0x14.
- Simultaneous events:
  - retire+stop in CAPTURE → record kept.
  - arm+stop in DONE → ARMED with count=0.
  - rd_ready held low in DONE → rd_* stable and count unchanged.
- With CPU_TRACE_TIMESTAMP_EN: arm at cycle 10 after reset, retires 3 cycles apart → rd_ts values differ by exactly 3.
